alu_issue_scheduler: RTL
========================

Name: alu_issue_scheduler

Overview:
- Reservation station and issue scheduler for the single-cycle ALU.
- Accepts dispatched ALU instructions from the decoder into a small entry buffer and tracks pending source operands.
- Captures operands from the common data bus (CDB).
- Each cycle, issues at most one ready entry to the ALU on registered en/rob_id/data_j/data_k/imm/type outputs.

Parameters:
- RS_SIZE, 8, number of entries; power of two, 2..16.
- IDX_W, 3, log2(RS_SIZE).

Ports:
- clk_in  input  1  clock, rising-edge.
- rst_in  input  1  reset, synchronous, active-low.
- rdy_in  input  1  global ready; low freezes every register.
- flush  input  1  mispredict flush; discards all entries.
- dis_valid  input  1  dispatch request.
- dis_ready  output  1  can accept a dispatch this cycle.
- dis_rob_id  input  32  ROB id of the instruction.
- dis_type  input  5  ALU op type (same encoding as the ALU).
- dis_imm  input  32  immediate.
- dis_qj_valid  input  1  operand j pending.
- dis_qj  input  32  ROB id producing j.
- dis_vj  input  32  j value when not pending.
- dis_qk_valid  input  1  operand k pending.
- dis_qk  input  32  ROB id producing k.
- dis_vk  input  32  k value when not pending.
- cdb_valid  input  1  CDB broadcast valid.
- cdb_rob_id  input  32  broadcast ROB id.
- cdb_value  input  32  broadcast value.
- alu_en  output  1  issue strobe to the ALU.
- alu_rob_id  output  32  issued ROB id.
- alu_data_j  output  32  issued operand j.
- alu_data_k  output  32  issued operand k.
- alu_imm  output  32  issued immediate.
- alu_type  output  5  issued op type.
- count  output  IDX_W+1  occupied entries.

Behaviour:
- Reset:
  - Active when rst_in is low at a rising edge; highest priority.
  - All busy bits clear, count=0, alu_en=0, all alu_* payloads 0.
  - dis_ready=1 after reset.
- Priority order: reset > rdy_in low (hold every register, including over flush/dispatch/CDB) > flush > normal operation.
- Entry state: busy, rob_id, type, imm, qj_valid, qj, vj, qk_valid, qk, vk.
- Ready: entry is ready when busy && !qj_valid && !qk_valid.
- dis_ready:
  - Combinational, equal to (count != RS_SIZE), from registered state only.
  - No dispatch-into-freed-slot in the same cycle.
- Dispatch (dis_valid && dis_ready):
  - Written into the lowest-index free entry.
  - Each operand is captured at dispatch when its q is valid and cdb_valid && cdb_rob_id == q matches in the same cycle: v=cdb_value, q_valid=0.
  - dis_valid while !dis_ready is ignored; the upstream must hold it.
- Wakeup: every busy entry with qj_valid && qj==cdb_rob_id && cdb_valid loads vj and clears qj_valid. The same applies to k; j and k may match the same broadcast.
- Select and issue:
  - Fixed priority: the lowest-index ready entry, evaluated on state as of the cycle start.
  - The winner's fields register into the alu_* outputs, alu_en=1 for exactly one cycle, and its busy bit clears at the same edge.
  - No ready entry: alu_en=0; payload holds its previous value.
- Latency: dispatch accepted at edge k with both operands ready -> alu_en high after edge k+1 (entry must be resident one cycle).
- count: +1 on dispatch, -1 on issue, unchanged when both happen in the same cycle; never exceeds RS_SIZE and never wraps below 0.
- Flush (rdy_in high): at the edge, all busy clear, count=0, alu_en=0. Same-cycle dispatch is dropped; same-cycle issue is suppressed.
- CDB with no matching tag has no effect. rob_id compares use the full 32 bits.

Optional Feature:
- Macro: ALU_ISSUE_SCHEDULER_CDB_BYPASS_EN.
- Defined:
  - An entry whose last pending operand(s) are satisfied by this cycle's CDB is treated as ready in this same cycle.
  - The matched operand is forwarded from cdb_value directly into alu_data_j/alu_data_k.
  - Wakeup-to-alu_en latency is 1 edge.
- Undefined:
  - The entry becomes ready only after the value is stored.
  - Wakeup-to-alu_en latency is 2 edges.
- Both builds:
  - Select priority is unchanged.
  - Dispatch-cycle capture is mandatory.

Test Plan:
- Ready dispatch: reset, then dispatch rob_id=5, type=3, vj=10, vk=20, imm=7, both ready -> alu_en=1 with those values one edge after acceptance; count returns 1->0.
- Pending wakeup: dispatch rob_id=6 with qj_valid, qj=4; then CDB {4, 0xABCD} -> without macro, alu_en=1, alu_data_j=0xABCD two edges after CDB; with macro, one edge.
- Full buffer:
  - Fill 8 entries, all with qj pending on id 9 -> count=8, dis_ready=0, extra dis_valid ignored.
  - CDB {9, 1} -> 8 consecutive issues in entry order 0..7.
- Same-cycle capture: dispatch with qk=3 while CDB {3, 0x55} -> entry stored ready, issues with alu_data_k=0x55.
- Flush and freeze:
  - With 3 entries resident, assert flush together with dis_valid -> count=0, no alu_en afterwards.
  - Hold rdy_in low with flush high -> nothing changes until rdy_in returns high.
- Mid-operation reset: rst_in low while alu_en=1 and count=4 -> next edge alu_en=0, count=0, all payloads 0, dis_ready=1.

Source files
------------

// File: rtl/alu_issue_scheduler.sv
// rtl/alu_issue_scheduler.sv - ALU reservation station with CDB wakeup and fixed-priority issue
// Optional feature macro: ALU_ISSUE_SCHEDULER_CDB_BYPASS_EN (same-cycle CDB wakeup-to-issue forwarding)
module alu_issue_scheduler #(
   parameter int RS_SIZE = 8,
   parameter int IDX_W   = 3
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              rdy_in,
   input  logic              flush,
   input  logic              dis_valid,
   output logic              dis_ready,
   input  logic [31:0]       dis_rob_id,
   input  logic [4:0]        dis_type,
   input  logic [31:0]       dis_imm,
   input  logic              dis_qj_valid,
   input  logic [31:0]       dis_qj,
   input  logic [31:0]       dis_vj,
   input  logic              dis_qk_valid,
   input  logic [31:0]       dis_qk,
   input  logic [31:0]       dis_vk,
   input  logic              cdb_valid,
   input  logic [31:0]       cdb_rob_id,
   input  logic [31:0]       cdb_value,
   output logic              alu_en,
   output logic [31:0]       alu_rob_id,
   output logic [31:0]       alu_data_j,
   output logic [31:0]       alu_data_k,
   output logic [31:0]       alu_imm,
   output logic [4:0]        alu_type,
   output logic [IDX_W:0]    count
);

   logic [RS_SIZE-1:0] busy_q, busy_d, qjv_q, qjv_d, qkv_q, qkv_d;
   logic [31:0]        rob_q [RS_SIZE];
   logic [31:0]        rob_d [RS_SIZE];
   logic [4:0]         type_q [RS_SIZE];
   logic [4:0]         type_d [RS_SIZE];
   logic [31:0]        imm_q [RS_SIZE];
   logic [31:0]        imm_d [RS_SIZE];
   logic [31:0]        qj_q [RS_SIZE];
   logic [31:0]        qj_d [RS_SIZE];
   logic [31:0]        vj_q [RS_SIZE];
   logic [31:0]        vj_d [RS_SIZE];
   logic [31:0]        qk_q [RS_SIZE];
   logic [31:0]        qk_d [RS_SIZE];
   logic [31:0]        vk_q [RS_SIZE];
   logic [31:0]        vk_d [RS_SIZE];

   logic [IDX_W:0]     count_q, count_d;
   logic               alu_en_q, alu_en_d;
   logic [31:0]        alu_rob_q, alu_rob_d, alu_j_q, alu_j_d, alu_k_q, alu_k_d, alu_imm_q, alu_imm_d;
   logic [4:0]         alu_type_q, alu_type_d;

   logic [RS_SIZE-1:0] jhit, khit, rdy_vec;
   logic [IDX_W-1:0]   free_idx, sel_idx;
   logic               sel_found, dis_fire;
   logic               dis_j_hit, dis_k_hit;
   logic [31:0]        sel_j, sel_k;

   assign dis_ready = (count_q != (IDX_W+1)'(RS_SIZE));
   assign dis_fire  = dis_valid && dis_ready;
   assign dis_j_hit = dis_qj_valid && cdb_valid && (dis_qj == cdb_rob_id);
   assign dis_k_hit = dis_qk_valid && cdb_valid && (dis_qk == cdb_rob_id);

   // With bypass, an operand matched by this cycle's broadcast counts as available now.
   always_comb begin
      jhit    = '0;
      khit    = '0;
      rdy_vec = '0;
      for (int i = 0; i < RS_SIZE; i++) begin
         jhit[i] = busy_q[i] && qjv_q[i] && cdb_valid && (qj_q[i] == cdb_rob_id);
         khit[i] = busy_q[i] && qkv_q[i] && cdb_valid && (qk_q[i] == cdb_rob_id);
`ifdef ALU_ISSUE_SCHEDULER_CDB_BYPASS_EN
         rdy_vec[i] = busy_q[i] && (!qjv_q[i] || jhit[i]) && (!qkv_q[i] || khit[i]);
`else
         rdy_vec[i] = busy_q[i] && !qjv_q[i] && !qkv_q[i];
`endif
      end
   end

   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int i = 0; i < RS_SIZE; i++) begin
         if (rdy_vec[i] && !sel_found) begin
            sel_found = 1'b1;
            sel_idx   = IDX_W'(i);
         end
      end
   end

   always_comb begin : free_search
      logic found;
      found    = 1'b0;
      free_idx = '0;
      for (int i = 0; i < RS_SIZE; i++) begin
         if (!busy_q[i] && !found) begin
            found    = 1'b1;
            free_idx = IDX_W'(i);
         end
      end
   end

   always_comb begin
      sel_j = vj_q[sel_idx];
      sel_k = vk_q[sel_idx];
`ifdef ALU_ISSUE_SCHEDULER_CDB_BYPASS_EN
      if (jhit[sel_idx]) sel_j = cdb_value;
      if (khit[sel_idx]) sel_k = cdb_value;
`endif
   end

   always_comb begin
      busy_d     = busy_q;
      qjv_d      = qjv_q;
      qkv_d      = qkv_q;
      rob_d      = rob_q;
      type_d     = type_q;
      imm_d      = imm_q;
      qj_d       = qj_q;
      vj_d       = vj_q;
      qk_d       = qk_q;
      vk_d       = vk_q;
      count_d    = count_q;
      alu_en_d   = 1'b0;
      alu_rob_d  = alu_rob_q;
      alu_j_d    = alu_j_q;
      alu_k_d    = alu_k_q;
      alu_imm_d  = alu_imm_q;
      alu_type_d = alu_type_q;
      if (flush) begin
         busy_d  = '0;
         count_d = '0;
      end else begin
         for (int i = 0; i < RS_SIZE; i++) begin
            if (jhit[i]) begin
               vj_d[i]  = cdb_value;
               qjv_d[i] = 1'b0;
            end
            if (khit[i]) begin
               vk_d[i]  = cdb_value;
               qkv_d[i] = 1'b0;
            end
         end
         if (sel_found) begin
            busy_d[sel_idx] = 1'b0;
            alu_en_d        = 1'b1;
            alu_rob_d       = rob_q[sel_idx];
            alu_j_d         = sel_j;
            alu_k_d         = sel_k;
            alu_imm_d       = imm_q[sel_idx];
            alu_type_d      = type_q[sel_idx];
         end
         // The free slot comes from start-of-cycle busy bits, so it never collides with the issued one.
         if (dis_fire) begin
            busy_d[free_idx] = 1'b1;
            rob_d[free_idx]  = dis_rob_id;
            type_d[free_idx] = dis_type;
            imm_d[free_idx]  = dis_imm;
            qj_d[free_idx]   = dis_qj;
            qk_d[free_idx]   = dis_qk;
            qjv_d[free_idx]  = dis_qj_valid && !dis_j_hit;
            qkv_d[free_idx]  = dis_qk_valid && !dis_k_hit;
            vj_d[free_idx]   = dis_j_hit ? cdb_value : dis_vj;
            vk_d[free_idx]   = dis_k_hit ? cdb_value : dis_vk;
         end
         count_d = count_q + (IDX_W+1)'(dis_fire) - (IDX_W+1)'(sel_found);
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         busy_q     <= '0;
         qjv_q      <= '0;
         qkv_q      <= '0;
         count_q    <= '0;
         alu_en_q   <= 1'b0;
         alu_rob_q  <= '0;
         alu_j_q    <= '0;
         alu_k_q    <= '0;
         alu_imm_q  <= '0;
         alu_type_q <= '0;
         for (int i = 0; i < RS_SIZE; i++) begin
            rob_q[i]  <= '0;
            type_q[i] <= '0;
            imm_q[i]  <= '0;
            qj_q[i]   <= '0;
            vj_q[i]   <= '0;
            qk_q[i]   <= '0;
            vk_q[i]   <= '0;
         end
      end else if (rdy_in) begin
         busy_q     <= busy_d;
         qjv_q      <= qjv_d;
         qkv_q      <= qkv_d;
         count_q    <= count_d;
         alu_en_q   <= alu_en_d;
         alu_rob_q  <= alu_rob_d;
         alu_j_q    <= alu_j_d;
         alu_k_q    <= alu_k_d;
         alu_imm_q  <= alu_imm_d;
         alu_type_q <= alu_type_d;
         rob_q      <= rob_d;
         type_q     <= type_d;
         imm_q      <= imm_d;
         qj_q       <= qj_d;
         vj_q       <= vj_d;
         qk_q       <= qk_d;
         vk_q       <= vk_d;
      end
   end

   assign alu_en     = alu_en_q;
   assign alu_rob_id = alu_rob_q;
   assign alu_data_j = alu_j_q;
   assign alu_data_k = alu_k_q;
   assign alu_imm    = alu_imm_q;
   assign alu_type   = alu_type_q;
   assign count      = count_q;

endmodule
